// File: rtl/trap_redirect_ctrl.sv
// Machine-mode trap/mret sequencer: captures trap CSRs, flushes the pipeline,
// then issues a single fetch redirect to the trap vector or the saved mepc.
//
// state      | meaning
// S_IDLE     | waiting for a trap or mret from commit
// S_FLUSH    | flush_o asserted until the pipeline reports drained
// S_REDIRECT | redirect_valid_o asserted with the latched target until fetch accepts
module trap_redirect_ctrl #(
  parameter int PC_WIDTH              = 39,
  parameter int XLEN                  = 64,
  parameter int EXCEPTION_CAUSE_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             trap_i,
  input  logic                             trap_irq_i,
  input  logic [PC_WIDTH-1:0]              trap_pc_i,
  input  logic [EXCEPTION_CAUSE_WIDTH-1:0] trap_ecause_i,
  input  logic                             mret_i,
  input  logic [PC_WIDTH-1:0]              mtvec_i,
  input  logic                             drain_done_i,
  input  logic                             redirect_ready_i,
  input  logic                             csr_mepc_we_i,
  input  logic [PC_WIDTH-1:0]              csr_mepc_wdata_i,
  input  logic                             csr_mstatus_we_i,
  input  logic                             csr_mie_wdata_i,
  input  logic                             csr_mpie_wdata_i,
  output logic                             flush_o,
  output logic                             redirect_valid_o,
  output logic [PC_WIDTH-1:0]              redirect_pc_o,
  output logic [PC_WIDTH-1:0]              mepc_o,
  output logic [XLEN-1:0]                  mcause_o,
  output logic                             mstatus_mie_o,
  output logic                             mstatus_mpie_o,
  output logic                             busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_mepc;
  logic [PC_WIDTH-1:0] r_target;
  logic [XLEN-1:0]     r_mcause;
  logic                r_mie;
  logic                r_mpie;
  logic                r_flush;
  logic                r_redirect_valid;

  logic                w_take_trap;
  logic                w_take_mret;
  logic [PC_WIDTH-1:0] w_base;
  logic [PC_WIDTH-1:0] w_vec_off;
  logic [PC_WIDTH-1:0] w_trap_target;
  logic [XLEN-1:0]     w_mcause;
  logic                w_unused_bits;

  assign w_take_trap   = (r_state == S_IDLE) && trap_i;
  assign w_take_mret   = (r_state == S_IDLE) && mret_i && !trap_i;
  assign w_base        = {mtvec_i[PC_WIDTH-1:2], 2'b00};
  assign w_vec_off     = PC_WIDTH'(trap_ecause_i) << 2;
  // Vectored offset applies only to interrupts; the add wraps at PC_WIDTH.
  assign w_trap_target = (mtvec_i[0] && trap_irq_i) ? (w_base + w_vec_off) : w_base;
  assign w_mcause      = {trap_irq_i, {(XLEN-1-EXCEPTION_CAUSE_WIDTH){1'b0}}, trap_ecause_i};
  assign w_unused_bits = ^{mtvec_i[1], trap_pc_i[1:0], csr_mepc_wdata_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_mepc           <= '0;
      r_target         <= '0;
      r_mcause         <= '0;
      r_mie            <= 1'b0;
      r_mpie           <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
    end else begin
      // Software writes first so a same-cycle trap/mret update overrides them.
      if (csr_mepc_we_i) r_mepc <= {csr_mepc_wdata_i[PC_WIDTH-1:2], 2'b00};
      if (csr_mstatus_we_i) begin
        r_mie  <= csr_mie_wdata_i;
        r_mpie <= csr_mpie_wdata_i;
      end
      case (r_state)
        S_IDLE: begin
          if (w_take_trap) begin
            r_mepc   <= {trap_pc_i[PC_WIDTH-1:2], 2'b00};
            r_mcause <= w_mcause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            r_target <= w_trap_target;
            r_flush  <= 1'b1;
            r_state  <= S_FLUSH;
          end else if (w_take_mret) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
            r_target <= r_mepc;
            r_flush  <= 1'b1;
            r_state  <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (drain_done_i) begin
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b1;
            r_state          <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready_i) begin
            r_redirect_valid <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: begin
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b0;
          r_state          <= S_IDLE;
        end
      endcase
    end
  end

  assign flush_o          = r_flush;
  assign redirect_valid_o = r_redirect_valid;
  assign redirect_pc_o    = r_target;
  assign mepc_o           = r_mepc;
  assign mcause_o         = r_mcause;
  assign mstatus_mie_o    = r_mie;
  assign mstatus_mpie_o   = r_mpie;
  assign busy_o           = (r_state != S_IDLE);

endmodule

// File: tb/tb_trap_redirect_ctrl.sv
// Bench for trap_redirect_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the trap rules.
module tb_trap_redirect_ctrl;

  localparam int PCW = 39;
  localparam int XL  = 64;
  localparam int ECW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           trap_i = 1'b0, trap_irq_i = 1'b0, mret_i = 1'b0;
  logic [PCW-1:0] trap_pc_i = '0, mtvec_i = '0, csr_mepc_wdata_i = '0;
  logic [ECW-1:0] trap_ecause_i = '0;
  logic           drain_done_i = 1'b1, redirect_ready_i = 1'b1;
  logic           csr_mepc_we_i = 1'b0, csr_mstatus_we_i = 1'b0;
  logic           csr_mie_wdata_i = 1'b0, csr_mpie_wdata_i = 1'b0;
  logic           flush_o, redirect_valid_o, mstatus_mie_o, mstatus_mpie_o, busy_o;
  logic [PCW-1:0] redirect_pc_o, mepc_o;
  logic [XL-1:0]  mcause_o;

  trap_redirect_ctrl #(.PC_WIDTH(PCW), .XLEN(XL), .EXCEPTION_CAUSE_WIDTH(ECW)) dut (
    .clk(clk), .rst(rst), .trap_i(trap_i), .trap_irq_i(trap_irq_i),
    .trap_pc_i(trap_pc_i), .trap_ecause_i(trap_ecause_i), .mret_i(mret_i),
    .mtvec_i(mtvec_i), .drain_done_i(drain_done_i), .redirect_ready_i(redirect_ready_i),
    .csr_mepc_we_i(csr_mepc_we_i), .csr_mepc_wdata_i(csr_mepc_wdata_i),
    .csr_mstatus_we_i(csr_mstatus_we_i), .csr_mie_wdata_i(csr_mie_wdata_i),
    .csr_mpie_wdata_i(csr_mpie_wdata_i), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .mepc_o(mepc_o), .mcause_o(mcause_o), .mstatus_mie_o(mstatus_mie_o),
    .mstatus_mpie_o(mstatus_mpie_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 = idle, 1 = flushing, 2 = redirecting.
  int             m_phase;
  logic [PCW-1:0] m_mepc, m_target;
  logic [XL-1:0]  m_mcause;
  logic           m_mie, m_mpie;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mepc = '0; m_target = '0; m_mcause = '0; m_mie = 1'b0; m_mpie = 1'b0;
  endtask

  task automatic model_step();
    int             n_phase;
    logic [PCW-1:0] n_mepc, n_target, base;
    logic [XL-1:0]  n_mcause;
    logic           n_mie, n_mpie;
    n_phase = m_phase; n_mepc = m_mepc; n_target = m_target;
    n_mcause = m_mcause; n_mie = m_mie; n_mpie = m_mpie;
    if (csr_mepc_we_i) n_mepc = csr_mepc_wdata_i - (csr_mepc_wdata_i % 4);
    if (csr_mstatus_we_i) begin n_mie = csr_mie_wdata_i; n_mpie = csr_mpie_wdata_i; end
    if (m_phase == 0 && trap_i) begin
      base     = mtvec_i - (mtvec_i % 4);
      n_target = (mtvec_i % 2 == 1 && trap_irq_i) ? base + PCW'(trap_ecause_i) * 4 : base;
      n_mepc   = trap_pc_i - (trap_pc_i % 4);
      n_mcause = trap_irq_i ? ((64'd1 << 63) + 64'(trap_ecause_i)) : 64'(trap_ecause_i);
      n_mpie   = m_mie;
      n_mie    = 1'b0;
      n_phase  = 1;
    end else if (m_phase == 0 && mret_i) begin
      n_mie    = m_mpie;
      n_mpie   = 1'b1;
      n_target = m_mepc;
      n_phase  = 1;
    end else if (m_phase == 1 && drain_done_i) begin
      n_phase = 2;
    end else if (m_phase == 2 && redirect_ready_i) begin
      n_phase = 0;
    end
    m_phase = n_phase; m_mepc = n_mepc; m_target = n_target;
    m_mcause = n_mcause; m_mie = n_mie; m_mpie = n_mpie;
  endtask

  task automatic compare_outputs();
    check_val("flush",    64'(flush_o),          64'(m_phase == 1));
    check_val("rvalid",   64'(redirect_valid_o), 64'(m_phase == 2));
    check_val("busy",     64'(busy_o),           64'(m_phase != 0));
    check_val("rpc",      64'(redirect_pc_o),    64'(m_target));
    check_val("mepc",     64'(mepc_o),           64'(m_mepc));
    check_val("mcause",   mcause_o,              m_mcause);
    check_val("mie",      64'(mstatus_mie_o),    64'(m_mie));
    check_val("mpie",     64'(mstatus_mpie_o),   64'(m_mpie));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    #1 rst = 1'b0;
  endtask

  task automatic clear_ctl();
    trap_i = 1'b0; mret_i = 1'b0; csr_mepc_we_i = 1'b0; csr_mstatus_we_i = 1'b0;
  endtask

  int nf, nv;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    rst = 1'b0;

    // MIE=1, MPIE=0 via software.
    csr_mstatus_we_i = 1'b1; csr_mie_wdata_i = 1'b1; csr_mpie_wdata_i = 1'b0;
    tick();
    clear_ctl();

    // Direct exception.
    mtvec_i = 39'h80000000; trap_i = 1'b1; trap_irq_i = 1'b0; trap_ecause_i = 4'd2;
    trap_pc_i = 39'h1006;
    tick();
    clear_ctl();
    check_val("direct_flush",  64'(flush_o),       64'd1);
    check_val("direct_mepc",   64'(mepc_o),        64'h1004);
    check_val("direct_mcause", mcause_o,           64'h2);
    check_val("direct_mie",    64'(mstatus_mie_o), 64'd0);
    check_val("direct_mpie",   64'(mstatus_mpie_o),64'd1);
    tick();
    check_val("direct_rvalid", 64'(redirect_valid_o), 64'd1);
    check_val("direct_rpc",    64'(redirect_pc_o),    64'h80000000);
    tick();
    check_val("direct_idle",   64'(busy_o), 64'd0);

    // Vectored interrupt.
    mtvec_i = 39'h80000001; trap_i = 1'b1; trap_irq_i = 1'b1; trap_ecause_i = 4'd7;
    tick();
    clear_ctl();
    check_val("vec_mcause", mcause_o, 64'h8000000000000007);
    check_val("vec_rpc",    64'(redirect_pc_o), 64'h8000001C);
    repeat (2) tick();

    // mret.
    csr_mepc_we_i = 1'b1; csr_mepc_wdata_i = 39'h2000;
    csr_mstatus_we_i = 1'b1; csr_mie_wdata_i = 1'b0; csr_mpie_wdata_i = 1'b1;
    tick();
    clear_ctl();
    mret_i = 1'b1;
    tick();
    clear_ctl();
    check_val("mret_mie",  64'(mstatus_mie_o),  64'd1);
    check_val("mret_mpie", 64'(mstatus_mpie_o), 64'd1);
    check_val("mret_rpc",  64'(redirect_pc_o),  64'h2000);
    repeat (2) tick();

    // Backpressure with ignored trap pulses.
    mtvec_i = 39'h80000000; trap_irq_i = 1'b0; trap_pc_i = 39'h4000;
    drain_done_i = 1'b0; redirect_ready_i = 1'b0; trap_i = 1'b1;
    nf = 0; nv = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (flush_o) nf++;
      if (redirect_valid_o) begin
        nv++;
        check_val("bp_rpc_stable", 64'(redirect_pc_o), 64'h80000000);
      end
      trap_i = (c == 2 || c == 5); trap_pc_i = 39'h7770;
      drain_done_i = (c >= 3);
      redirect_ready_i = (c >= 6);
    end
    check_val("bp_flush_cycles",  64'(nf), 64'd4);
    check_val("bp_rvalid_cycles", 64'(nv), 64'd3);
    check_val("bp_mepc_kept",     64'(mepc_o), 64'h4000);
    drain_done_i = 1'b1; redirect_ready_i = 1'b1;

    // Trap + mret + software mepc write in one cycle.
    trap_i = 1'b1; mret_i = 1'b1; trap_pc_i = 39'h5008;
    csr_mepc_we_i = 1'b1; csr_mepc_wdata_i = 39'h3000;
    tick();
    clear_ctl();
    check_val("collide_mepc", 64'(mepc_o), 64'h5008);
    repeat (2) tick();

    // Reset in the middle of REDIRECT.
    trap_i = 1'b1; redirect_ready_i = 1'b0;
    tick();
    clear_ctl();
    tick();
    check_val("rst_pre_rvalid", 64'(redirect_valid_o), 64'd1);
    pulse_reset();
    check_val("rst_rvalid", 64'(redirect_valid_o), 64'd0);
    check_val("rst_busy",   64'(busy_o),           64'd0);
    check_val("rst_rpc",    64'(redirect_pc_o),    64'd0);
    redirect_ready_i = 1'b1;
    nv = 0;
    repeat (3) begin
      tick();
      if (redirect_valid_o) nv++;
    end
    check_val("rst_no_redirect", 64'(nv), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      trap_i           = ($urandom_range(0, 3) == 0);
      trap_irq_i       = $urandom_range(0, 1);
      trap_pc_i        = PCW'({$urandom, $urandom});
      trap_ecause_i    = ECW'($urandom);
      mret_i           = ($urandom_range(0, 3) == 0);
      mtvec_i          = ($urandom_range(0, 7) == 0) ? {PCW{1'b1}} : PCW'({$urandom, $urandom});
      drain_done_i     = $urandom_range(0, 1);
      redirect_ready_i = $urandom_range(0, 1);
      csr_mepc_we_i    = ($urandom_range(0, 7) == 0);
      csr_mepc_wdata_i = PCW'({$urandom, $urandom});
      csr_mstatus_we_i = ($urandom_range(0, 7) == 0);
      csr_mie_wdata_i  = $urandom_range(0, 1);
      csr_mpie_wdata_i = $urandom_range(0, 1);
      tick();
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_redirect_ctrl.md
TRAP_REDIRECT_CTRL -- requirements
Module: trap_redirect_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 39, meaning PC and trap-target width.
REQ-002 SHALL have parameter XLEN, default 64, meaning mcause register width.
REQ-003 SHALL have parameter EXCEPTION_CAUSE_WIDTH, default 4, meaning cause code width.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port trap_i  in  1  global trap request from commit (exception or interrupt).
REQ-007 SHALL have port trap_irq_i  in  1  qualifies trap_i as an interrupt.
REQ-008 SHALL have port trap_pc_i  in  PC_WIDTH  PC of the trapping instruction.
REQ-009 SHALL have port trap_ecause_i  in  EXCEPTION_CAUSE_WIDTH  cause code.
REQ-010 SHALL have port mret_i  in  1  global mret from commit.
REQ-011 SHALL have port mtvec_i  in  PC_WIDTH  trap vector; bit0=1 selects vectored mode.
REQ-012 SHALL have port drain_done_i  in  1  pipeline reports flush complete.
REQ-013 SHALL have port redirect_ready_i  in  1  fetch accepts redirect.
REQ-014 SHALL have ports csr_mepc_we_i (in, 1), csr_mepc_wdata_i (in, PC_WIDTH), csr_mstatus_we_i (in, 1), csr_mie_wdata_i (in, 1), csr_mpie_wdata_i (in, 1)  software CSR writes.
REQ-015 SHALL have port flush_o  out  1  pipeline flush request.
REQ-016 SHALL have ports redirect_valid_o (out, 1) and redirect_pc_o (out, PC_WIDTH)  fetch redirect.
REQ-017 SHALL have ports mepc_o (out, PC_WIDTH), mcause_o (out, XLEN), mstatus_mie_o (out, 1), mstatus_mpie_o (out, 1), busy_o (out, 1).

Function
REQ-018 SHALL implement FSM states IDLE, FLUSH, REDIRECT; busy_o = (state != IDLE).
REQ-019 In IDLE, trap_i=1 SHALL capture mepc={trap_pc_i[PC_WIDTH-1:2],2'b00}, mcause={trap_irq_i, zeros, trap_ecause_i}, MPIE<=MIE, MIE<=0, compute target, go FLUSH.
REQ-020 Target SHALL be {mtvec_i[PC_WIDTH-1:2],2'b00} + (trap_ecause_i<<2) when mtvec_i[0]=1 and trap_irq_i=1, else {mtvec_i[PC_WIDTH-1:2],2'b00}; sum truncated to PC_WIDTH (wraps).
REQ-021 In IDLE, mret_i=1 with trap_i=0 SHALL set MIE<=MPIE, MPIE<=1, target=current mepc, go FLUSH.
REQ-022 trap_i and mret_i both high in IDLE SHALL be handled as trap; mret ignored.
REQ-023 trap_i and mret_i outside IDLE SHALL be ignored with no state change.
REQ-024 FLUSH: flush_o=1 every cycle; on drain_done_i=1 go REDIRECT next edge (minimum one FLUSH cycle; drain_done_i in IDLE/REDIRECT ignored).
REQ-025 REDIRECT: redirect_valid_o=1, redirect_pc_o=target held stable; on redirect_ready_i=1 go IDLE next edge.
REQ-026 Latency: trap sampled at edge N -> flush_o high in cycle N+1; with drain_done_i and redirect_ready_i tied high, redirect_valid_o high exactly cycle N+2, busy_o low at N+3.
REQ-027 flush_o and redirect_valid_o SHALL be registered, mutually exclusive, and 0 in IDLE.
REQ-028 Software CSR writes SHALL apply in any state next edge; same-cycle hardware trap/mret update of the same field SHALL win.
REQ-029 csr_mepc_we_i SHALL write mepc with bits [1:0] forced to 0; it SHALL NOT alter a target already latched.

Reset
REQ-030 rst=1 SHALL asynchronously force state IDLE, mepc_o=0, mcause_o=0, MIE=0, MPIE=0, target/redirect_pc_o=0, flush_o=0, redirect_valid_o=0, busy_o=0.
REQ-031 Reset asserted in FLUSH or REDIRECT SHALL abort the sequence; no redirect issued after release.

Verification
REQ-032 Direct trap: mtvec_i=0x80000000, MIE=1, trap_i=1, trap_irq_i=0, ecause=2, pc=0x1006 -> mepc_o=0x1004, mcause_o=0x2, MIE=0, MPIE=1, redirect_pc_o=0x80000000.
REQ-033 Vectored irq: mtvec_i=0x80000001, trap_irq_i=1, ecause=7 -> redirect_pc_o=0x8000001C, mcause_o=0x8000000000000007.
REQ-034 mret: mepc=0x2000, MPIE=1, MIE=0, mret_i=1 -> MIE=1, MPIE=1, redirect_pc_o=0x2000.
REQ-035 Backpressure: drain_done_i low 3 cycles, redirect_ready_i low 2 cycles -> flush_o high 4 cycles, redirect_valid_o high 3 cycles, pc stable; trap_i pulsed meanwhile ignored.
REQ-036 Collision: trap_i and mret_i same cycle plus csr_mepc_we_i=0x3000 -> mepc_o=trapping PC, not 0x3000.
REQ-037 rst pulse mid-REDIRECT -> all outputs 0 immediately, busy_o=0, no redirect_valid_o after release.
